// File: rtl/card_shoe.sv
// card_shoe: finite-shoe rank dealer; SHOE_AUTO_RESHUFFLE_EN refills an empty shoe on the next request
module card_shoe #(
  parameter int DECKS = 1,
  parameter int CW = $clog2(52 * DECKS + 1)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          req,
  output logic [3:0]    card_out,
  output logic          card_valid,
  output logic          busy,
  output logic          empty,
  output logic [CW-1:0] cards_left
);
  localparam int MAXR = 4 * DECKS;
  localparam int NW = $clog2(MAXR + 1);
  localparam logic [NW-1:0] MAXV = NW'(MAXR);
  localparam logic [CW-1:0] FULL = CW'(52 * DECKS);
`ifdef SHOE_AUTO_RESHUFFLE_EN
  localparam bit RESHUF = 1'b1;
`else
  localparam bit RESHUF = 1'b0;
`endif
  typedef enum logic {IDLE, SEARCH} state_t;
  state_t state_q, state_d;
  logic [3:0] ctr_q, ctr_d, cand_q, cand_d, card_out_q, card_out_d, idx;
  logic card_valid_q, card_valid_d;
  logic [CW-1:0] cards_left_q, cards_left_d;
  logic [NW-1:0] cnt_q [13];
  logic [NW-1:0] cnt_d [13];
  assign idx = cand_q - 4'd1;
  assign card_out = card_out_q;
  assign card_valid = card_valid_q;
  assign busy = state_q == SEARCH;
  assign cards_left = cards_left_q;
  assign empty = cards_left_q == '0;
  // Next state: free-running rank counter, request capture, and linear search past exhausted ranks
  always_comb begin
    state_d = state_q;
    ctr_d = (ctr_q == 4'd13) ? 4'd1 : ctr_q + 4'd1;
    cand_d = cand_q;
    card_out_d = card_out_q;
    card_valid_d = 1'b0;
    cards_left_d = cards_left_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (req && (!empty || RESHUF)) begin
        cand_d = ctr_q;
        state_d = SEARCH;
        if (empty) begin
          cnt_d = '{default: '0};
          cards_left_d = FULL;
        end
      end
    end else if (cnt_q[idx] < MAXV) begin
      cnt_d[idx] = cnt_q[idx] + NW'(1);
      card_out_d = cand_q;
      card_valid_d = 1'b1;
      cards_left_d = cards_left_q - CW'(1);
      state_d = IDLE;
    end else begin
      cand_d = (cand_q == 4'd13) ? 4'd1 : cand_q + 4'd1;
    end
  end
  // State registers; reset aborts any search in progress and refills the shoe
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ctr_q <= 4'd1;
      cand_q <= 4'd1;
      card_out_q <= 4'd0;
      card_valid_q <= 1'b0;
      cards_left_q <= FULL;
      cnt_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      ctr_q <= ctr_d;
      cand_q <= cand_d;
      card_out_q <= card_out_d;
      card_valid_q <= card_valid_d;
      cards_left_q <= cards_left_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: doc/card_shoe.md
# card_shoe

Card source for the Baccarat datapath. It sits directly upstream of the player/dealer card registers and replaces a bare free-running rank counter with a finite shoe of 4×DECKS cards per rank, so no rank can be dealt more often than a real shoe allows. Each deal request returns one rank (1 = Ace … 13 = King) with a one-cycle valid strobe. Randomness comes from the unpredictable timing of the user's KEY presses relative to a free-running rank counter on CLOCK_50.

## Interface
- DECKS, 1, number of 52-card decks in the shoe; per-rank limit MAXR = 4×DECKS.
- CW, $clog2(52×DECKS+1), width of cards_left.

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous and active-high.
- req  in  1  deal request, level-sampled; acted on only in IDLE.
- card_out  out  4  last dealt rank, 1..13; 0 after reset.
- card_valid  out  1  one-cycle pulse, high in the cycle card_out takes a new value.
- busy  out  1  high while a request is being serviced (state ≠ IDLE).
- empty  out  1  high when cards_left == 0.
- cards_left  out  CW  cards remaining in the shoe.

## Operation
- Free counter ctr: 4 bits, sequence 1,2,…,13,1,… and advances every cycle regardless of state.
- Per-rank counters cnt[1..13]: each holds 0..MAXR and counts dealt cards of that rank.
- States:
  - IDLE: if req && !empty, then cand ← ctr and go to SEARCH. If req && empty, see Configuration. Otherwise stay.
  - SEARCH: if cnt[cand] < MAXR, then cnt[cand]++, card_out ← cand, card_valid ← 1, cards_left−−, go to IDLE. Otherwise cand ← (cand == 13) ? 1 : cand+1 and stay.
- SEARCH always terminates within 13 cycles: entering it requires cards_left > 0, so some rank is below MAXR.
- req held high re-triggers after each return to IDLE, giving back-to-back deals. Upstream logic pulses req once per slow-clock edge.
- req while busy is ignored. It is not queued.
- card_out holds its value between deals.

## Timing
- Reset (async assert) gives: state IDLE, ctr = 1, cnt[*] = 0, card_out = 0, card_valid = 0, busy = 0, cards_left = 52×DECKS, empty = 0.
- The k-th rising edge after reset deasserts samples ctr = ((k−1) mod 13)+1.
- Latency: req sampled at edge N gives card_valid high after edge N+1+s, where s = number of exhausted ranks skipped (0..12). The minimum is 2 cycles from req to strobe.
- busy is high from after edge N until the edge that raises card_valid, and low in the card_valid cycle.
- card_valid is high for exactly one cycle, coincident with the new card_out, cards_left and empty values.
- Reset asserted mid-SEARCH aborts the search. No card is dealt and all counters revert to reset values.
- Arithmetic: cnt saturates logically at MAXR and is never incremented past it. cands wrap 13→1. Value 0 and values 14–15 are never produced after the first deal.

## Configuration
- SHOE_AUTO_RESHUFFLE_EN defined: req in IDLE with empty = 1 clears all cnt to 0, sets cards_left = 52×DECKS, cand ← ctr, and enters SEARCH in the same edge. The deal then completes normally, with latency identical to a non-empty deal.
- Not defined: req with empty = 1 is ignored. State stays IDLE, no card_valid, card_out unchanged, and empty stays high until reset.

## Test plan
- Reset: hold reset for 3 cycles, then check card_out = 0, card_valid = 0, busy = 0, cards_left = 52, empty = 0 (DECKS = 1).
- First deal: req high for the 3rd edge only. Expect cand = 3, busy = 1 for 1 cycle, card_out = 3, card_valid pulse after the 4th edge, cards_left = 51.
- Exhaustion skip: deal four 5s (req timed at ctr = 5), then request at ctr = 5 again. Expect 1 skip cycle, card_out = 6, latency 3 cycles.
- Wrap: exhaust all four Kings, then request at ctr = 13. Expect card_out = 1 (wrap 13→1).
- Drain 52 cards with req held high. Expect every rank dealt exactly 4 times, empty = 1, cards_left = 0. A 53rd req gives no card_valid without the macro; with SHOE_AUTO_RESHUFFLE_EN it gives a card and cards_left = 51.
- Reset mid-SEARCH: with Kings exhausted, req at ctr = 13, then assert reset in the SEARCH cycle. Expect no card_valid, card_out = 0, cards_left = 52.
